// File: rtl/rv32_bus_arbiter_if.sv
// Bundle of core-side request/response signals and the shared memory port for rv32_bus_arbiter.
// master: the core and memory that drive requests and responses; slave: the arbiter itself.
interface rv32_bus_arbiter_if;
  logic        instr_req_in;
  logic [31:0] instr_address_in;
  logic        instr_ready_out;
  logic        instr_error_out;
  logic [31:0] instr_read_value_out;

  logic        data_read_in;
  logic        data_write_in;
  logic [31:0] data_address_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic        data_ready_out;
  logic        data_error_out;
  logic [31:0] data_read_value_out;

  logic [31:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in;
  logic        mem_ready_in;

  modport master (
    output instr_req_in, instr_address_in,
    input  instr_ready_out, instr_error_out, instr_read_value_out,
    output data_read_in, data_write_in, data_address_in, data_write_mask_in, data_write_value_in,
    input  data_ready_out, data_error_out, data_read_value_out,
    input  mem_address_out, mem_read_out, mem_write_out, mem_write_mask_out, mem_write_value_out,
    output mem_read_value_in, mem_ready_in
  );

  modport slave (
    input  instr_req_in, instr_address_in,
    output instr_ready_out, instr_error_out, instr_read_value_out,
    input  data_read_in, data_write_in, data_address_in, data_write_mask_in, data_write_value_in,
    output data_ready_out, data_error_out, data_read_value_out,
    output mem_address_out, mem_read_out, mem_write_out, mem_write_mask_out, mem_write_value_out,
    input  mem_read_value_in, mem_ready_in
  );
endinterface

// File: rtl/rv32_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a wait-state timeout that aborts accesses the memory never acknowledges.
module rv32_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset,
  rv32_bus_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StBusyInstr = 2'd1;
  localparam logic [1:0] StBusyData  = 2'd2;

  localparam logic GrantInstr = 1'b0;
  localparam logic GrantData  = 1'b1;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        instr_ready_q, instr_ready_d;
  logic        instr_error_q, instr_error_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic        data_ready_q, data_ready_d;
  logic        data_error_q, data_error_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic instr_req;
  logic data_req;
  logic grant_data;
  logic timeout;
  logic unused_addr_lsbs;

  // A requester whose ready pulse is high is still holding its old request; ignore it.
  assign instr_req  = bus.instr_req_in & ~instr_ready_q;
  assign data_req   = (bus.data_read_in | bus.data_write_in) & ~data_ready_q;
  assign grant_data = data_req & (~instr_req | (last_grant_q == GrantInstr));
  assign timeout    = TimeoutEn && !bus.mem_ready_in && (wait_cnt_q == TimeoutLast);

  assign unused_addr_lsbs = ^{bus.instr_address_in[1:0], bus.data_address_in[1:0]};

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_mask_d    = mem_mask_q;
    mem_wdata_d   = mem_wdata_q;
    instr_ready_d = 1'b0;
    instr_error_d = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_ready_d  = 1'b0;
    data_error_d  = 1'b0;
    data_rdata_d  = data_rdata_q;

    case (state_q)
      StIdle: begin
        if (instr_req || data_req) begin
          wait_cnt_d = 16'd0;
          if (grant_data) begin
            state_d       = StBusyData;
            last_grant_d  = GrantData;
            mem_address_d = {bus.data_address_in[31:2], 2'b00};
            mem_write_d   = bus.data_write_in;
            mem_read_d    = bus.data_read_in & ~bus.data_write_in;
            mem_mask_d    = bus.data_write_mask_in;
            mem_wdata_d   = bus.data_write_value_in;
          end else begin
            state_d       = StBusyInstr;
            last_grant_d  = GrantInstr;
            mem_address_d = {bus.instr_address_in[31:2], 2'b00};
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_mask_d    = 4'b0000;
            mem_wdata_d   = 32'd0;
          end
        end
      end
      StBusyInstr, StBusyData: begin
        if (bus.mem_ready_in || timeout) begin
          state_d     = StIdle;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          mem_mask_d  = 4'b0000;
          mem_wdata_d = 32'd0;
          if (state_q == StBusyInstr) begin
            instr_ready_d = 1'b1;
            instr_error_d = timeout;
            instr_rdata_d = timeout ? 32'd0 : bus.mem_read_value_in;
          end else begin
            data_ready_d = 1'b1;
            data_error_d = timeout;
            data_rdata_d = timeout ? 32'd0 : bus.mem_read_value_in;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      last_grant_q  <= GrantInstr;
      wait_cnt_q    <= 16'd0;
      mem_address_q <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_mask_q    <= 4'b0000;
      mem_wdata_q   <= 32'd0;
      instr_ready_q <= 1'b0;
      instr_error_q <= 1'b0;
      instr_rdata_q <= 32'd0;
      data_ready_q  <= 1'b0;
      data_error_q  <= 1'b0;
      data_rdata_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_mask_q    <= mem_mask_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_ready_q <= instr_ready_d;
      instr_error_q <= instr_error_d;
      instr_rdata_q <= instr_rdata_d;
      data_ready_q  <= data_ready_d;
      data_error_q  <= data_error_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign bus.instr_ready_out      = instr_ready_q;
  assign bus.instr_error_out      = instr_error_q;
  assign bus.instr_read_value_out = instr_rdata_q;
  assign bus.data_ready_out       = data_ready_q;
  assign bus.data_error_out       = data_error_q;
  assign bus.data_read_value_out  = data_rdata_q;
  assign bus.mem_address_out      = mem_address_q;
  assign bus.mem_read_out         = mem_read_q;
  assign bus.mem_write_out        = mem_write_q;
  assign bus.mem_write_mask_out   = mem_mask_q;
  assign bus.mem_write_value_out  = mem_wdata_q;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Scoreboard bench for rv32_bus_arbiter: a timeout-4 instance for the main scenarios and a
// timeout-disabled instance for the long-wait case.
module tb_rv32_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32_bus_arbiter_if bus ();
  rv32_bus_arbiter_if bus0 ();

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nt (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  typedef struct {
    bit          is_data;
    bit          err;
    bit          chk_value;
    logic [31:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Memory responder knobs: wait_cfg < 0 means never acknowledge.
  int          wait_cfg    = 0;
  bit          use_fixed   = 1'b0;
  logic [31:0] fixed_value = 32'd0;
  bit          auto_drop   = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic void sb_push(input bit is_data, input bit err, input bit chk,
                                  input logic [31:0] v);
    exp_t e;
    e.is_data   = is_data;
    e.err       = err;
    e.chk_value = chk;
    e.value     = v;
    sb_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sb_empty(input string tag, input int bound);
    int i = 0;
    while (sb_q.size() != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin : responder
    int busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_out || bus.mem_write_out) begin
        bus.mem_read_value_in = use_fixed ? fixed_value : mem_word(bus.mem_address_out);
        bus.mem_ready_in      = (wait_cfg >= 0) && (busy_cnt >= wait_cfg);
        busy_cnt++;
      end else begin
        bus.mem_ready_in = 1'b0;
        busy_cnt         = 0;
      end
    end
  end

  initial begin : requester_drop
    forever begin
      @(negedge clk);
      if (auto_drop && bus.instr_ready_out) bus.instr_req_in = 1'b0;
      if (auto_drop && bus.data_ready_out) begin
        bus.data_read_in  = 1'b0;
        bus.data_write_in = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.instr_ready_out || bus.data_ready_out) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_pulse_unexpected", {30'd0, bus.instr_ready_out, bus.data_ready_out}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_requester", 32'(bus.data_ready_out), 32'(e.is_data));
          check_eq("sb_single_pulse", 32'(bus.instr_ready_out & bus.data_ready_out), 32'd0);
          if (e.is_data) begin
            check_eq("sb_data_error", 32'(bus.data_error_out), 32'(e.err));
            if (e.chk_value) check_eq("sb_data_value", bus.data_read_value_out, e.value);
          end else begin
            check_eq("sb_instr_error", 32'(bus.instr_error_out), 32'(e.err));
            if (e.chk_value) check_eq("sb_instr_value", bus.instr_read_value_out, e.value);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    int last_cyc;
    int i;
    int pulses;

    reset                    = 1'b1;
    bus.instr_req_in         = 1'b0;
    bus.instr_address_in     = 32'd0;
    bus.data_read_in         = 1'b0;
    bus.data_write_in        = 1'b0;
    bus.data_address_in      = 32'd0;
    bus.data_write_mask_in   = 4'd0;
    bus.data_write_value_in  = 32'd0;
    bus0.instr_req_in        = 1'b0;
    bus0.instr_address_in    = 32'd0;
    bus0.data_read_in        = 1'b0;
    bus0.data_write_in       = 1'b0;
    bus0.data_address_in     = 32'd0;
    bus0.data_write_mask_in  = 4'd0;
    bus0.data_write_value_in = 32'd0;
    bus0.mem_read_value_in   = 32'd0;
    bus0.mem_ready_in        = 1'b0;

    tick(2);
    check_eq("rst_mem_address", bus.mem_address_out, 32'd0);
    check_eq("rst_mem_strobes", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd0);
    check_eq("rst_ready", {30'd0, bus.instr_ready_out, bus.data_ready_out}, 32'd0);
    check_eq("rst_instr_value", bus.instr_read_value_out, 32'd0);
    reset = 1'b0;

    // Single zero-wait fetch.
    use_fixed            = 1'b1;
    fixed_value          = 32'hDEAD_BEEF;
    wait_cfg             = 0;
    bus.instr_address_in = 32'h0000_1006;
    bus.instr_req_in     = 1'b1;
    sb_push(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick(1);
    check_eq("fetch_mem_address", bus.mem_address_out, 32'h0000_1004);
    check_eq("fetch_mem_rw", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd2);
    check_eq("fetch_mem_mask", 32'(bus.mem_write_mask_out), 32'd0);
    tick(1);
    check_eq("fetch_ready", 32'(bus.instr_ready_out), 32'd1);
    check_eq("fetch_value", bus.instr_read_value_out, 32'hDEAD_BEEF);
    tick(2);
    use_fixed = 1'b0;

    // Both requesting continuously: data, instr, data, instr at 2-cycle spacing.
    auto_drop            = 1'b0;
    bus.instr_address_in = 32'h0000_0100;
    bus.data_address_in  = 32'h0000_2000;
    bus.instr_req_in     = 1'b1;
    bus.data_read_in     = 1'b1;
    sb_push(1'b1, 1'b0, 1'b1, mem_word(32'h2000));
    sb_push(1'b0, 1'b0, 1'b1, mem_word(32'h0100));
    sb_push(1'b1, 1'b0, 1'b1, mem_word(32'h2000));
    sb_push(1'b0, 1'b0, 1'b1, mem_word(32'h0100));
    n        = 0;
    last_cyc = 0;
    i        = 0;
    while (n < 4 && i < 40) begin
      @(negedge clk);
      i++;
      if (bus.instr_ready_out || bus.data_ready_out) begin
        if (n > 0) check_eq("alt_spacing", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        n++;
      end
    end
    check_eq("alt_pulse_count", 32'(n), 32'd4);
    bus.instr_req_in = 1'b0;
    bus.data_read_in = 1'b0;
    auto_drop        = 1'b1;
    wait_sb_empty("alt_drained", 10);
    tick(2);

    // Data write with three wait states; write wins over read.
    wait_cfg                = 3;
    bus.data_address_in     = 32'h0000_0020;
    bus.data_write_mask_in  = 4'b0011;
    bus.data_write_value_in = 32'h1234_5678;
    bus.data_read_in        = 1'b1;
    bus.data_write_in       = 1'b1;
    sb_push(1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_eq("wr_mem_rw", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd1);
      check_eq("wr_mem_address", bus.mem_address_out, 32'h0000_0020);
      check_eq("wr_mem_mask", 32'(bus.mem_write_mask_out), 32'd3);
      check_eq("wr_mem_value", bus.mem_write_value_out, 32'h1234_5678);
    end
    tick(1);
    check_eq("wr_ready", 32'(bus.data_ready_out), 32'd1);
    check_eq("wr_strobes_cleared", {27'd0, bus.mem_write_mask_out, bus.mem_write_out}, 32'd0);
    check_eq("wr_value_cleared", bus.mem_write_value_out, 32'd0);
    bus.data_write_mask_in  = 4'd0;
    bus.data_write_value_in = 32'd0;
    tick(2);

    // Timeout after four unacknowledged busy cycles.
    wait_cfg             = -1;
    bus.instr_address_in = 32'h0000_0040;
    bus.instr_req_in     = 1'b1;
    sb_push(1'b0, 1'b1, 1'b1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check_eq("to_busy_read", 32'(bus.mem_read_out), 32'd1);
    end
    tick(1);
    check_eq("to_strobe_dropped", 32'(bus.mem_read_out), 32'd0);
    check_eq("to_ready", 32'(bus.instr_ready_out), 32'd1);
    check_eq("to_error", 32'(bus.instr_error_out), 32'd1);
    check_eq("to_value", bus.instr_read_value_out, 32'd0);
    tick(2);

    // Acknowledge on the fourth busy cycle: success, not timeout.
    wait_cfg             = 3;
    bus.instr_address_in = 32'h0000_0044;
    bus.instr_req_in     = 1'b1;
    sb_push(1'b0, 1'b0, 1'b1, mem_word(32'h0044));
    tick(5);
    check_eq("to_edge_ready", 32'(bus.instr_ready_out), 32'd1);
    check_eq("to_edge_error", 32'(bus.instr_error_out), 32'd0);
    check_eq("to_edge_value", bus.instr_read_value_out, mem_word(32'h0044));
    tick(2);

    // Reset in the middle of a data write.
    wait_cfg                = -1;
    bus.data_address_in     = 32'h0000_0080;
    bus.data_write_mask_in  = 4'hF;
    bus.data_write_value_in = 32'hAAAA_5555;
    bus.data_write_in       = 1'b1;
    tick(1);
    check_eq("rstmid_busy", 32'(bus.mem_write_out), 32'd1);
    tick(1);
    reset = 1'b1;
    tick(1);
    bus.data_write_in = 1'b0;
    check_eq("rstmid_mem_address", bus.mem_address_out, 32'd0);
    check_eq("rstmid_mem_strobes", {30'd0, bus.mem_read_out, bus.mem_write_out}, 32'd0);
    check_eq("rstmid_mem_mask", 32'(bus.mem_write_mask_out), 32'd0);
    check_eq("rstmid_mem_value", bus.mem_write_value_out, 32'd0);
    check_eq("rstmid_instr_value", bus.instr_read_value_out, 32'd0);
    check_eq("rstmid_data_value", bus.data_read_value_out, 32'd0);
    tick(1);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (bus.data_ready_out) pulses++;
    end
    check_eq("rstmid_no_ready", 32'(pulses), 32'd0);

    // First tie after reset goes to data.
    wait_cfg             = 0;
    bus.instr_address_in = 32'h0000_0200;
    bus.data_address_in  = 32'h0000_0300;
    bus.data_write_mask_in  = 4'd0;
    bus.data_write_value_in = 32'd0;
    bus.instr_req_in     = 1'b1;
    bus.data_read_in     = 1'b1;
    sb_push(1'b1, 1'b0, 1'b1, mem_word(32'h0300));
    sb_push(1'b0, 1'b0, 1'b1, mem_word(32'h0200));
    wait_sb_empty("tie_drained", 20);
    tick(2);

    // Timeout disabled: a 1000-cycle wait still completes normally.
    bus0.instr_address_in = 32'h0000_0306;
    bus0.instr_req_in     = 1'b1;
    tick(1);
    check_eq("nt_mem_address", bus0.mem_address_out, 32'h0000_0304);
    check_eq("nt_mem_read", 32'(bus0.mem_read_out), 32'd1);
    pulses = 0;
    for (int k = 0; k < 1000; k++) begin
      tick(1);
      if (bus0.instr_ready_out) pulses++;
    end
    check_eq("nt_no_abort", 32'(pulses), 32'd0);
    check_eq("nt_still_busy", 32'(bus0.mem_read_out), 32'd1);
    bus0.mem_read_value_in = 32'hCAFE_F00D;
    bus0.mem_ready_in      = 1'b1;
    tick(1);
    bus0.mem_ready_in = 1'b0;
    bus0.instr_req_in = 1'b0;
    check_eq("nt_ready", 32'(bus0.instr_ready_out), 32'd1);
    check_eq("nt_error", 32'(bus0.instr_error_out), 32'd0);
    check_eq("nt_value", bus0.instr_read_value_out, 32'hCAFE_F00D);

    tick(2);
    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
